// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - main-memory port arbiter for the write buffer and the d/i cache refill paths
module mem_arbiter #(
  parameter int MAXWB   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swc,
  input  logic        wben,
  input  logic [29:0] wbadr,
  input  logic [31:0] wbdata,
  input  logic [3:0]  wbbyteen,
  output logic        wbdone,
  input  logic        den,
  input  logic [29:0] dadr,
  output logic        ddone,
  input  logic        ien,
  input  logic [29:0] iadr,
  output logic        idone,
  output logic [31:0] rdata,
  output logic        err,
  output logic [29:0] memadr,
  output logic [31:0] memwdata,
  output logic [3:0]  membyteen,
  output logic        memrwb,
  output logic        memen,
  input  logic [31:0] memrdata,
  input  logic        memdone
);

  localparam int SW = $clog2(MAXWB + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {G_WB, G_D, G_I} grant_t;

  state_t        state, state_nx;
  grant_t        grant, grant_nx;
  logic [SW-1:0] streak, streak_nx;
  logic [7:0]    tcnt, tcnt_nx;

  logic        memen_nx, memrwb_nx, err_nx;
  logic        wbdone_nx, ddone_nx, idone_nx;
  logic [29:0] memadr_nx;
  logic [31:0] memwdata_nx, rdata_nx;
  logic [3:0]  membyteen_nx;

  // Request classification used by the IDLE grant decision.
  logic read_pend, wb_starved, pick_wb, pick_i;

  assign read_pend  = den | ien;
  // After MAXWB back-to-back writes with a read waiting, the write buffer yields once.
  assign wb_starved = read_pend && (streak == SW'(MAXWB));
  assign pick_wb    = wben && !wb_starved;
  // Read winner: swc hands the icache priority, otherwise icache only when dcache is idle.
  assign pick_i     = ien && (swc || !den);

  // Next-state and registered-output computation; everything holds unless a state changes it.
  always_comb begin
    state_nx     = state;
    grant_nx     = grant;
    streak_nx    = streak;
    tcnt_nx      = tcnt;
    memen_nx     = memen;
    memrwb_nx    = memrwb;
    memadr_nx    = memadr;
    memwdata_nx  = memwdata;
    membyteen_nx = membyteen;
    rdata_nx     = rdata;
    err_nx       = err;
    wbdone_nx    = 1'b0;
    ddone_nx     = 1'b0;
    idone_nx     = 1'b0;

    case (state)
      IDLE: begin
        err_nx   = 1'b0;
        memen_nx = 1'b0;
        if (wben || read_pend) begin
          state_nx = BUSY;
          memen_nx = 1'b1;
          tcnt_nx  = 8'd0;
          if (pick_wb) begin
            grant_nx     = G_WB;
            memrwb_nx    = 1'b0;
            memadr_nx    = wbadr;
            memwdata_nx  = wbdata;
            membyteen_nx = wbbyteen;
            if (!read_pend)
              streak_nx = '0;
            else if (streak != SW'(MAXWB))
              streak_nx = streak + SW'(1);
          end else begin
            // Only reachable with a read pending; memwdata keeps the last write data.
            grant_nx     = pick_i ? G_I : G_D;
            memrwb_nx    = 1'b1;
            memadr_nx    = pick_i ? iadr : dadr;
            membyteen_nx = 4'hF;
            streak_nx    = '0;
          end
        end
      end

      BUSY: begin
        if (memdone || (tcnt == 8'(TIMEOUT - 1))) begin
          state_nx  = RESP;
          memen_nx  = 1'b0;
          wbdone_nx = (grant == G_WB);
          ddone_nx  = (grant == G_D);
          idone_nx  = (grant == G_I);
          if (memdone) begin
            err_nx = 1'b0;
            if (grant != G_WB)
              rdata_nx = memrdata;
          end else begin
            // Memory never answered: abort and flag the requester instead of hanging the port.
            err_nx  = 1'b1;
            tcnt_nx = tcnt + 8'd1;
          end
        end else begin
          tcnt_nx = tcnt + 8'd1;
        end
      end

      RESP: begin
        state_nx = IDLE;
        err_nx   = 1'b0;
      end

      default: begin
        state_nx = IDLE;
        memen_nx = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= G_WB;
      streak    <= '0;
      tcnt      <= 8'd0;
      memen     <= 1'b0;
      memrwb    <= 1'b1;
      memadr    <= 30'd0;
      memwdata  <= 32'd0;
      membyteen <= 4'd0;
      rdata     <= 32'd0;
      err       <= 1'b0;
      wbdone    <= 1'b0;
      ddone     <= 1'b0;
      idone     <= 1'b0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      streak    <= streak_nx;
      tcnt      <= tcnt_nx;
      memen     <= memen_nx;
      memrwb    <= memrwb_nx;
      memadr    <= memadr_nx;
      memwdata  <= memwdata_nx;
      membyteen <= membyteen_nx;
      rdata     <= rdata_nx;
      err       <= err_nx;
      wbdone    <= wbdone_nx;
      ddone     <= ddone_nx;
      idone     <= idone_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;

  localparam int MAXWB   = 4;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset, swc;
  logic        wben, den, ien;
  logic [29:0] wbadr, dadr, iadr;
  logic [31:0] wbdata;
  logic [3:0]  wbbyteen;
  logic        wbdone, ddone, idone;
  logic [31:0] rdata;
  logic        err;
  logic [29:0] memadr;
  logic [31:0] memwdata;
  logic [3:0]  membyteen;
  logic        memrwb, memen;
  logic [31:0] memrdata;
  logic        memdone;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: write streak, last read data, last write data.
  int          m_streak;
  logic [31:0] m_rdata;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MAXWB(MAXWB), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .swc(swc),
    .wben(wben), .wbadr(wbadr), .wbdata(wbdata), .wbbyteen(wbbyteen), .wbdone(wbdone),
    .den(den), .dadr(dadr), .ddone(ddone),
    .ien(ien), .iadr(iadr), .idone(idone),
    .rdata(rdata), .err(err),
    .memadr(memadr), .memwdata(memwdata), .membyteen(membyteen),
    .memrwb(memrwb), .memen(memen), .memrdata(memrdata), .memdone(memdone)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Requester ids: 0 = write buffer, 1 = dcache, 2 = icache; -1 = nothing pending.
  function automatic int model_pick();
    int  order [3];
    bit  pend  [3];
    pend[0] = wben;
    pend[1] = den;
    pend[2] = ien;
    if (swc) order = '{0, 2, 1};
    else     order = '{0, 1, 2};
    for (int k = 0; k < 3; k++) begin
      if (order[k] == 0 && m_streak == MAXWB && (den || ien)) continue;
      if (pend[order[k]]) return order[k];
    end
    return -1;
  endfunction

  // One full transaction from IDLE: grant, lat extra BUSY cycles, memdone, RESP, back to IDLE.
  task automatic do_txn(input int lat, input logic [31:0] rd, input bit keep, output int g);
    logic [29:0] eadr;
    logic [31:0] ewd;
    logic [3:0]  ebe;
    logic        erwb;
    g = model_pick();
    eadr = '0; ewd = m_wdata; ebe = 4'hF; erwb = 1'b1;
    case (g)
      0: begin
        eadr = wbadr; ewd = wbdata; ebe = wbbyteen; erwb = 1'b0;
        m_wdata  = wbdata;
        m_streak = (den || ien) ? ((m_streak < MAXWB) ? m_streak + 1 : MAXWB) : 0;
      end
      1: begin eadr = dadr; m_streak = 0; end
      2: begin eadr = iadr; m_streak = 0; end
      default: ;
    endcase
    tick();
    chk("grant_memen",     32'(memen),     32'(g >= 0));
    chk("grant_memrwb",    32'(memrwb),    32'(erwb));
    chk("grant_memadr",    32'(memadr),    32'(eadr));
    chk("grant_memwdata",  memwdata,       ewd);
    chk("grant_membyteen", 32'(membyteen), 32'(ebe));
    chk("grant_nodone",    32'({wbdone, ddone, idone}), 32'd0);
    for (int c = 0; c < lat; c++) begin
      tick();
      chk("busy_memen", 32'(memen), 32'd1);
    end
    memdone  = 1'b1;
    memrdata = rd;
    tick();
    memdone  = 1'b0;
    memrdata = $urandom;
    if (g == 1 || g == 2) m_rdata = rd;
    chk("resp_done", 32'({wbdone, ddone, idone}), 32'({g == 0, g == 1, g == 2}));
    chk("resp_err",   32'(err),   32'd0);
    chk("resp_rdata", rdata,      m_rdata);
    chk("resp_memen", 32'(memen), 32'd0);
    if (!keep) begin
      if (g == 0) wben = 1'b0;
      if (g == 1) den  = 1'b0;
      if (g == 2) ien  = 1'b0;
    end
    tick();
    chk("idle_done",  32'({wbdone, ddone, idone}), 32'd0);
    chk("idle_memen", 32'(memen), 32'd0);
  endtask

  initial begin
    int g;
    int n;
    int exp_order [3];

    reset = 1'b1; swc = 1'b0;
    wben = 1'b0; den = 1'b0; ien = 1'b0;
    wbadr = '0; dadr = '0; iadr = '0; wbdata = '0; wbbyteen = '0;
    memrdata = '0; memdone = 1'b0;
    m_streak = 0; m_rdata = '0; m_wdata = '0;
    repeat (3) tick();
    chk("rst_memen",     32'(memen),     32'd0);
    chk("rst_memrwb",    32'(memrwb),    32'd1);
    chk("rst_memadr",    32'(memadr),    32'd0);
    chk("rst_memwdata",  memwdata,       32'd0);
    chk("rst_membyteen", 32'(membyteen), 32'd0);
    chk("rst_done",      32'({wbdone, ddone, idone}), 32'd0);
    chk("rst_rdata",     rdata,          32'd0);
    chk("rst_err",       32'(err),       32'd0);
    reset = 1'b0;
    tick();
    chk("idle_noreq_memen", 32'(memen), 32'd0);

    // Single dcache read with minimum latency.
    den = 1'b1; dadr = 30'h4AD;
    do_txn(0, 32'h21212121, 1'b0, g);
    chk("dread_grant", 32'(g), 32'd1);
    chk("dread_rdata", rdata, 32'h21212121);

    // Write pass-through; rdata must survive the write.
    wben = 1'b1; wbadr = 30'h4AD; wbdata = 32'hDDCCBBAA; wbbyteen = 4'b0011;
    do_txn(2, 32'h5A5A5A5A, 1'b0, g);
    chk("write_grant", 32'(g), 32'd0);
    chk("write_rdata_held", rdata, 32'h21212121);

    // All three requesters at one edge, swc = 0 then swc = 1.
    for (int s = 0; s < 2; s++) begin
      swc = s[0];
      if (s == 0) exp_order = '{0, 1, 2};
      else        exp_order = '{0, 2, 1};
      wben = 1'b1; wbadr = 30'(32'h100 + s); wbdata = $urandom; wbbyteen = 4'hF;
      den  = 1'b1; dadr  = 30'(32'h200 + s);
      ien  = 1'b1; iadr  = 30'(32'h300 + s);
      for (int k = 0; k < 3; k++) begin
        do_txn(k, $urandom, 1'b0, g);
        chk("simul_order", 32'(g), 32'(exp_order[k]));
      end
    end

    // Starvation: write buffer never lets go, dcache read asked twice.
    swc = 1'b0;
    wben = 1'b1; wbbyteen = 4'b1010;
    for (int r = 0; r < 2; r++) begin
      den = 1'b1; dadr = 30'(32'h3000 + r);
      for (int k = 0; k < MAXWB; k++) begin
        wbadr = 30'($urandom); wbdata = $urandom;
        do_txn(0, $urandom, 1'b1, g);
        chk("starve_write", 32'(g), 32'd0);
      end
      do_txn(1, $urandom, 1'b0, g);
      chk("starve_read", 32'(g), 32'd1);
    end
    wbadr = 30'h777; wbdata = 32'hCAFEF00D;
    do_txn(0, $urandom, 1'b0, g);
    chk("starve_resume", 32'(g), 32'd0);

    // Timeout: memory never answers an icache read.
    ien = 1'b1; iadr = 30'h1234;
    chk("to_pick", 32'(model_pick()), 32'd2);
    m_streak = 0;
    tick();
    chk("to_memen", 32'(memen), 32'd1);
    n = 0;
    while (memen === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TIMEOUT));
    chk("to_done",   32'({wbdone, ddone, idone}), 32'b001);
    chk("to_err",    32'(err), 32'd1);
    chk("to_rdata",  rdata, m_rdata);
    ien = 1'b0;
    tick();
    chk("to_idle_done", 32'({wbdone, ddone, idone}), 32'd0);
    chk("to_idle_err",  32'(err), 32'd0);
    den = 1'b1; dadr = 30'h0ABC;
    do_txn(1, 32'h600DF00D, 1'b0, g);
    chk("to_after_grant", 32'(g), 32'd1);

    // Reset in the middle of a read; the held request is granted again afterwards.
    den = 1'b1; dadr = 30'h2A5;
    tick();
    chk("rstmid_memen", 32'(memen), 32'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_streak = 0; m_rdata = '0; m_wdata = '0;
    chk("rstmid_memen_drop", 32'(memen), 32'd0);
    chk("rstmid_nodone",     32'({wbdone, ddone, idone}), 32'd0);
    chk("rstmid_rdata",      rdata, 32'd0);
    do_txn(1, $urandom, 1'b0, g);
    chk("rstmid_regrant", 32'(g), 32'd1);

    // Random traffic: requesters come and go, latencies vary, swc flips between grants.
    for (int t = 0; t < 40; t++) begin
      if (!wben && $urandom_range(0, 1) == 1) begin
        wben = 1'b1; wbadr = 30'($urandom); wbdata = $urandom; wbbyteen = 4'($urandom);
      end
      if (!den && $urandom_range(0, 1) == 1) begin
        den = 1'b1; dadr = 30'($urandom);
      end
      if (!ien && $urandom_range(0, 1) == 1) begin
        ien = 1'b1; iadr = 30'($urandom);
      end
      if (!wben && !den && !ien) begin
        den = 1'b1; dadr = 30'($urandom);
      end
      swc = 1'($urandom_range(0, 1));
      do_txn($urandom_range(0, 4), $urandom, 1'b0, g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
